// File: rtl/seq_rotate_ctrl_if.sv
// seq_rotate_ctrl_if
//   Request/response bundle for the sequential rotator.
//   master : requester side (drives req_val, in_, amt, op, resp_rdy)
//   slave  : rotator side   (drives req_rdy, resp_val, resp_msg)
//   Request carries the operand, the rotate amount and the direction
//   (op = 0 left, op = 1 right). Response carries the rotated operand.
interface seq_rotate_ctrl_if #(
  parameter int nbits = 8
);
  localparam int aw = $clog2(nbits);

  logic             req_val;
  logic             req_rdy;
  logic [nbits-1:0] in_;
  logic [aw-1:0]    amt;
  logic             op;
  logic             resp_val;
  logic             resp_rdy;
  logic [nbits-1:0] resp_msg;

  modport master (
    output req_val, in_, amt, op, resp_rdy,
    input  req_rdy, resp_val, resp_msg
  );

  modport slave (
    input  req_val, in_, amt, op, resp_rdy,
    output req_rdy, resp_val, resp_msg
  );
endinterface

// File: rtl/seq_rotate_ctrl.sv
// seq_rotate_ctrl
//   Rotates an nbits-wide operand by amt positions, one bit position per
//   clock, then presents the result until the consumer takes it.
//   Ports:
//     clk   : rising-edge clock
//     reset : asynchronous, active-high; returns the block to IDLE
//     bus   : seq_rotate_ctrl_if.slave request/response bundle
//
//   state | meaning
//   IDLE  | waiting for a request (req_rdy high except the bubble cycle)
//   BUSY  | rotating one bit per cycle, counter tracks remaining steps
//   DONE  | result valid on resp_msg, held until resp_rdy
//
//   All outputs come straight from flops; resp_msg is the data register.
module seq_rotate_ctrl #(
  parameter int nbits = 8
) (
  input logic           clk,
  input logic           reset,
  seq_rotate_ctrl_if.slave bus
);
  localparam int aw = $clog2(nbits);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [nbits-1:0] data_q, data_d;
  logic [aw-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             req_rdy_q, req_rdy_d;
  logic             resp_val_q, resp_val_d;
  logic             fire;

  assign fire = (state_q == IDLE) && req_rdy_q && bus.req_val;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;

    case (state_q)
      IDLE: begin
        if (fire) begin
          data_d  = bus.in_;
          cnt_d   = bus.amt;
          dir_d   = bus.op;
          state_d = (bus.amt == '0) ? DONE : BUSY;
        end
      end

      BUSY: begin
        if (dir_q) data_d = {data_q[0], data_q[nbits-1:1]};
        else       data_d = {data_q[nbits-2:0], data_q[nbits-1]};
        // Counter saturates at zero so it can never wrap, even if BUSY
        // were somehow entered with a zero count.
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        if (cnt_q <= aw'(1)) state_d = DONE;
      end

      DONE: begin
        if (bus.resp_rdy) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // req_rdy needs the block to have been in IDLE for a full cycle, which
    // inserts one bubble after a response handshake and drops it on fire.
    req_rdy_d  = (state_d == IDLE) && (state_q == IDLE);
    resp_val_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      data_q     <= '0;
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      req_rdy_q  <= 1'b1;
      resp_val_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      req_rdy_q  <= req_rdy_d;
      resp_val_q <= resp_val_d;
    end
  end

  assign bus.req_rdy  = req_rdy_q;
  assign bus.resp_val = resp_val_q;
  assign bus.resp_msg = data_q;
endmodule

// File: tb/tb_seq_rotate_ctrl.sv
// Bench for seq_rotate_ctrl: one 4-bit and one 8-bit instance on a shared
// clock and reset, exercised one at a time (w_sel picks the active one).
module tb_seq_rotate_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   w_sel = 8;

  always #5 clk = ~clk;

  seq_rotate_ctrl_if #(.nbits(4)) if4 ();
  seq_rotate_ctrl_if #(.nbits(8)) if8 ();

  seq_rotate_ctrl #(.nbits(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));
  seq_rotate_ctrl #(.nbits(8)) dut8 (.clk(clk), .reset(reset), .bus(if8));

  logic       cur_req_rdy;
  logic       cur_resp_val;
  logic [7:0] cur_msg;

  always_comb begin
    if (w_sel == 4) begin
      cur_req_rdy  = if4.req_rdy;
      cur_resp_val = if4.resp_val;
      cur_msg      = {4'b0000, if4.resp_msg};
    end else begin
      cur_req_rdy  = if8.req_rdy;
      cur_resp_val = if8.resp_val;
      cur_msg      = if8.resp_msg;
    end
  end

  // Reference: rotate as arithmetic on an integer; right by s == left by w-s.
  function automatic logic [7:0] rot_model(logic [7:0] x, int a, logic o, int w);
    int m, v, s;
    m = (1 << w) - 1;
    v = int'(x) & m;
    s = a % w;
    if (o) s = (w - s) % w;
    return 8'(((v << s) | (v >> (w - s))) & m);
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic rv, logic [7:0] din, int a, logic o, logic rr);
    logic [7:0] av;
    av = 8'(a);
    if (w_sel == 4) begin
      if4.req_val  = rv;
      if4.in_      = din[3:0];
      if4.amt      = av[1:0];
      if4.op       = o;
      if4.resp_rdy = rr;
    end else begin
      if8.req_val  = rv;
      if8.in_      = din;
      if8.amt      = av[2:0];
      if8.op       = o;
      if8.resp_rdy = rr;
    end
  endtask

  // One full transaction: fire, count cycles to resp_val, stall, handshake,
  // then confirm the bubble and the return of req_rdy.
  task automatic run(string tag, logic [7:0] din, int a, logic o, int stall);
    logic [7:0] exp;
    int n;
    int cyc;
    exp = rot_model(din, a, o, w_sel);
    n = 0;
    while (!cur_req_rdy && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_rdy_pre"}, {7'd0, cur_req_rdy}, 8'd1);
    drive(1'b1, din, a, o, 1'b0);
    step();
    drive(1'b0, 8'($urandom), int'($urandom_range(0, w_sel - 1)), 1'($urandom), 1'b0);
    chk({tag, "_rdy_after_fire"}, {7'd0, cur_req_rdy}, 8'd0);
    cyc = 1;
    while (!cur_resp_val && cyc <= 20) begin
      step();
      cyc++;
    end
    chk({tag, "_latency"}, 8'(cyc), 8'(a + 1));
    chk({tag, "_msg"}, cur_msg, exp);
    for (int s = 0; s < stall; s++) begin
      drive(1'($urandom), 8'($urandom), int'($urandom_range(0, w_sel - 1)), 1'($urandom), 1'b0);
      step();
      chk({tag, "_stall_val"}, {7'd0, cur_resp_val}, 8'd1);
      chk({tag, "_stall_msg"}, cur_msg, exp);
      chk({tag, "_stall_rdy"}, {7'd0, cur_req_rdy}, 8'd0);
    end
    drive(1'b0, 8'd0, 0, 1'b0, 1'b1);
    step();
    drive(1'b0, 8'd0, 0, 1'b0, 1'b0);
    chk({tag, "_bubble_val"}, {7'd0, cur_resp_val}, 8'd0);
    chk({tag, "_bubble_rdy"}, {7'd0, cur_req_rdy}, 8'd0);
    step();
    chk({tag, "_rdy_back"}, {7'd0, cur_req_rdy}, 8'd1);
    chk({tag, "_val_low"}, {7'd0, cur_resp_val}, 8'd0);
  endtask

  initial begin
    int stale;
    logic [7:0] din;
    int a;
    logic o;

    w_sel = 4; drive(1'b0, 8'd0, 0, 1'b0, 1'b0);
    w_sel = 8; drive(1'b0, 8'd0, 0, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    step();

    w_sel = 4;
    chk("rst4_rdy", {7'd0, cur_req_rdy}, 8'd1);
    chk("rst4_val", {7'd0, cur_resp_val}, 8'd0);
    chk("rst4_msg", cur_msg, 8'd0);
    w_sel = 8;
    chk("rst8_rdy", {7'd0, cur_req_rdy}, 8'd1);
    chk("rst8_val", {7'd0, cur_resp_val}, 8'd0);
    chk("rst8_msg", cur_msg, 8'd0);

    w_sel = 4;
    run("w4_l1", 8'b0000_1101, 1, 1'b0, 0);
    chk("w4_l1_const", rot_model(8'b0000_1101, 1, 1'b0, 4), 8'b0000_1011);
    run("w4_r0", 8'b0000_1101, 0, 1'b1, 0);
    run("w4_r3", 8'b0000_0110, 3, 1'b1, 1);

    w_sel = 8;
    run("w8_l3", 8'b0101_1101, 3, 1'b0, 0);
    run("w8_r2", 8'b1101_0101, 2, 1'b1, 0);
    run("w8_l7", 8'b1000_0001, 7, 1'b0, 0);
    run("w8_bp", 8'b1011_0010, 5, 1'b1, 4);

    // Reset in cycle 2 of an amt=6 transaction, with req_val held high
    // through reset to show nothing is accepted while reset is asserted.
    drive(1'b1, 8'hA7, 6, 1'b0, 1'b0);
    step();
    drive(1'b0, 8'h00, 0, 1'b0, 1'b0);
    step();
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_val", {7'd0, cur_resp_val}, 8'd0);
    chk("mid_rst_rdy", {7'd0, cur_req_rdy}, 8'd1);
    chk("mid_rst_msg", cur_msg, 8'd0);
    drive(1'b1, 8'h3C, 2, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1 drive(1'b0, 8'h00, 0, 1'b0, 1'b1);
    #2 reset = 1'b0;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (cur_resp_val || !cur_req_rdy) stale++;
    end
    chk("post_rst_stale", 8'(stale), 8'd0);
    drive(1'b0, 8'h00, 0, 1'b0, 1'b0);
    run("post_rst_txn", 8'b0110_1001, 6, 1'b0, 2);

    for (int wi = 0; wi < 2; wi++) begin
      w_sel = (wi == 0) ? 4 : 8;
      for (int k = 0; k < 20; k++) begin
        din = 8'($urandom);
        a   = int'($urandom_range(0, w_sel - 1));
        o   = 1'($urandom);
        run("rand", din, a, o, int'($urandom_range(0, 3)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seq_rotate_ctrl.md
SEQ_ROTATE_CTRL -- requirements
Module: seq_rotate_ctrl

Interface
REQ-001 The block SHALL have one parameter: nbits, default 8, data width (power of two, >= 4).
REQ-002 The block SHALL have port clk, input, 1, sole clock, with all state updated on the rising edge.
REQ-003 The block SHALL have port reset, input, 1, reset that is asynchronous and active-high.
REQ-004 The block SHALL have port req_val, input, 1, request valid.
REQ-005 The block SHALL have port req_rdy, output, 1, request ready.
REQ-006 The block SHALL have port in_, input, nbits, operand to rotate.
REQ-007 The block SHALL have port amt, input, $clog2(nbits), rotate amount.
REQ-008 The block SHALL have port op, input, 1, rotate direction: 0 = left, 1 = right.
REQ-009 The block SHALL have port resp_val, output, 1, result valid.
REQ-010 The block SHALL have port resp_rdy, input, 1, result ready.
REQ-011 The block SHALL have port resp_msg, output, nbits, rotated result.

Function
REQ-012 The block SHALL implement a three-state FSM with states IDLE, BUSY and DONE.
REQ-013 The block SHALL drive req_rdy = 1 only in IDLE and resp_val = 1 only in DONE; at most one transaction is in flight, with no overlap.
REQ-014 Request acceptance (fire) SHALL occur on a rising edge where req_val && req_rdy.
- On fire, capture in_ into the data register, amt into the down-counter, and op into the direction register.
- in_, amt and op SHALL be ignored at all other times.
REQ-015 On fire, the next state SHALL be DONE if amt == 0, else BUSY.
REQ-016 In BUSY, each cycle SHALL:
- rotate the data register by exactly one bit in the latched direction (left: {d[n-2:0], d[n-1]}; right: {d[0], d[n-1:1]});
- decrement the counter;
- go to DONE on the edge where the counter goes from 1 to 0.
REQ-017 Latency SHALL be as follows: if fire is at edge E0, BUSY occupies cycles 1..amt after E0 and resp_val first rises in cycle amt+1 (cycle 1 when amt == 0).
REQ-018 resp_msg SHALL equal the data register at all times.
- In DONE it SHALL equal in_ rotated by amt mod nbits in direction op.
- It SHALL hold stable while resp_val && !resp_rdy.
REQ-019 In DONE, the FSM SHALL go to IDLE on the edge where resp_rdy = 1; req_rdy SHALL be 1 the following cycle, giving one bubble cycle and no same-cycle re-accept.
REQ-020 Backpressure: resp_rdy may stay low indefinitely; state, resp_val and resp_msg SHALL hold with no data loss.
REQ-021 req_val while not in IDLE SHALL have no effect; the requester holds its request until req_rdy.
REQ-022 The maximum amount (nbits-1) SHALL take nbits-1 BUSY cycles; the counter SHALL never wrap.
REQ-023 All outputs SHALL be glitch-free registered or state-decoded values; there SHALL be no combinational path from any input to any output.

Reset
REQ-024 Asserting reset SHALL immediately (asynchronously) force:
- state = IDLE;
- data register, counter and direction register = 0;
- req_rdy = 1, resp_val = 0, resp_msg = 0.
REQ-025 Reset asserted during BUSY or DONE SHALL discard the in-flight transaction; no response SHALL be produced after reset deasserts.
REQ-026 While reset is high, no request SHALL be accepted.

Verification
REQ-027 nbits=4, in_=1101, amt=1, op=0, resp_rdy=1: resp_val rises in cycle 2 after fire with resp_msg=1011; req_rdy=1 in cycle 4.
REQ-028 nbits=4, in_=1101, amt=0, op=1: resp_val in cycle 1 with resp_msg=1101, and no BUSY cycle occurs.
REQ-029 nbits=8 left and right rotates:
- in_=0101_1101, amt=3, op=0: resp_msg=1110_1010 in cycle 4.
- in_=1101_0101, amt=2, op=1: resp_msg=0111_0101 in cycle 3.
- amt=7 takes 7 BUSY cycles.
REQ-030 Backpressure: nbits=8, amt=5, resp_rdy=0 for 4 cycles after resp_val rises. resp_val and resp_msg SHALL hold, req_rdy SHALL stay 0, and req_val pulses in that window SHALL be ignored; resp_rdy=1 then completes the transaction.
REQ-031 Reset mid-operation: assert reset in cycle 2 of an amt=6 transaction. The block SHALL immediately show resp_val=0, req_rdy=1, resp_msg=0; after deassertion, no stale response appears and a new request completes correctly.
REQ-032 Random test: 20 random {in_, amt, op} per nbits in {4, 8}, with random resp_rdy stalls, checked against a software rotate model.
